onewire_temp_responder: RTL and testbench
=========================================

# onewire_temp_responder

Synthesizable 1-Wire slave that emulates a DS18B20 temperature sensor on the heater controller's sensor bus. It answers bus resets with a presence pulse and accepts Skip ROM (0xCC), then Convert T (0x44) or Read Scratchpad (0xBE). It serves a 16-bit temperature word supplied from fabric. It stands in for the physical sensor in hardware-in-the-loop bring-up and lets the 1-Wire master be exercised in simulation. Defaults assume a 27 MHz CLK.

## Interface
- RESET_MIN_CYC, 12960, minimum low time recognised as bus reset (480 us)
- PRES_WAIT_CYC, 810, delay from end of reset low to presence start (30 us)
- PRES_LEN_CYC, 3240, presence pulse length (120 us)
- SAMPLE_CYC, 810, write-slot sample point after falling edge (30 us)
- TX_HOLD_CYC, 810, time DQ is held low when transmitting a 0 (30 us)
- CONV_CYC, 54000, conversion busy time (2 ms)
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- DQ  inout  1  1-Wire line; block drives only 0 or z (open-drain)
- TEMP_IN  in  16  temperature word to report, DS18B20 format
- BUSY  out  1  high while a conversion is in progress
- LAST_CMD  out  8  last fully received command byte (ROM or function)
- PRESENCE  out  1  one-cycle pulse when presence drive begins
- ERR  out  1  one-cycle pulse on an unsupported command byte

## Operation
- DQ is passed through a 2-flop synchronizer (dq_s). A falling edge is dq_s going 1→0. All timing is measured on dq_s.
- Low counter: 16-bit, saturating. It counts while dq_s=0 and the block is not driving DQ, and clears when dq_s=1. When dq_s rises with the count ≥ RESET_MIN_CYC, a bus reset is taken from any state: go to PRES_WAIT, clear the bit counter and shift register.
- States:
  - IDLE: DQ released. Falling edges are ignored; only reset detection is active.
  - PRES_WAIT: wait PRES_WAIT_CYC, then go to PRES_DRIVE.
  - PRES_DRIVE: drive DQ low for PRES_LEN_CYC, pulse PRESENCE on the first cycle, release, then go to ROM_RX.
  - ROM_RX / FUNC_RX: each falling edge arms a slot timer. At SAMPLE_CYC, sample dq_s into an 8-bit register, LSB first. Extra falling edges before the sample are ignored. After 8 bits, update LAST_CMD and decode.
  - ROM_RX decode: 0xCC goes to FUNC_RX. Any other byte pulses ERR and goes to IDLE.
  - FUNC_RX decode: 0x44 latches scratch ← TEMP_IN, loads the conversion counter with CONV_CYC, and goes to IDLE. 0xBE goes to TX_DATA with bit index 0. Any other byte pulses ERR and goes to IDLE.
  - TX_DATA: each falling edge starts a slot. If scratch[idx]=0, drive DQ low from the cycle after the edge is detected for TX_HOLD_CYC, then release. If scratch[idx]=1, leave DQ released. idx increments at slot end. After bit 15 completes, go to IDLE.
- BUSY = (conversion counter ≠ 0). The counter decrements every cycle and is independent of the FSM. A bus reset does not cancel it. A Convert T while BUSY reloads the counter and re-latches scratch.
- scratch reset value is 16'h0550 (85 °C power-on value).

## Timing
- Reset values: DQ=z, BUSY=0, LAST_CMD=8'h00, PRESENCE=0, ERR=0, state IDLE, scratch=16'h0550, all counters 0. RST_N mid-drive releases DQ immediately (asynchronous).
- Synchronizer latency is 2 cycles. All times quoted are ±3 cycles relative to the actual DQ edge.
- Presence starts PRES_WAIT_CYC after the reset rising edge and lasts exactly PRES_LEN_CYC.
- LAST_CMD, ERR, and the scratch latch update on the same cycle as the 8th sample.
- A low period < RESET_MIN_CYC never causes a reset, in any state.
- A reset rising edge coincident with a slot sample is handled as reset; the sample is discarded.
- The low counter is held at 0 while the block drives DQ, so the block's own presence or TX-0 can never trigger a reset.

## Test plan
- RST_N release, then DQ low 702 us: PRESENCE pulses once; DQ low from 30 us to 150 us after the line is released; state ROM_RX.
- Reset, then write slots 0xCC, 0x44 with TEMP_IN=16'h0191: LAST_CMD=8'h44; BUSY high for 54000 cycles; no DQ drive during the write slots.
- Reset, 0xCC, 0xBE, 16 read slots (2 us low, master samples at 12 us): master reads 16'h0191 LSB first. The same sequence before any Convert T reads 16'h0550.
- Reset, ROM byte 0x55: ERR pulses once; LAST_CMD=8'h55; following slots draw no DQ drive until the next reset.
- Reset after 5 TX bits: TX aborted; presence generated; a new 0xCC/0xBE restarts at bit 0. A 400 us low in IDLE produces no presence.
- RST_N asserted during PRES_DRIVE: DQ released within the same cycle; all outputs return to reset values.

Source files
------------

// File: rtl/onewire_temp_responder.sv
// onewire_temp_responder
// 1-Wire slave that emulates a DS18B20 behind Skip ROM.
// It answers a bus reset with a presence pulse.
// It accepts Convert T (0x44) and Read Scratchpad (0xBE).
// DQ is open-drain: the block only ever drives 0 or releases the line.
//
// Handshake: none. Every bus event is time-based on the synchronised line.
// A slot starts on a falling edge of dq_s. Write slots are sampled SAMPLE_CYC
// cycles later. Read slots hold DQ low for TX_HOLD_CYC cycles when the bit is 0.
module onewire_temp_responder #(
    parameter int RESET_MIN_CYC = 12960,
    parameter int PRES_WAIT_CYC = 810,
    parameter int PRES_LEN_CYC  = 3240,
    parameter int SAMPLE_CYC    = 810,
    parameter int TX_HOLD_CYC   = 810,
    parameter int CONV_CYC      = 54000
) (
    input  logic        CLK,
    input  logic        RST_N,
    inout  wire         DQ,
    input  logic [15:0] TEMP_IN,
    output logic        BUSY,
    output logic [7:0]  LAST_CMD,
    output logic        PRESENCE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRES_WAIT,
        S_PRES_DRIVE,
        S_ROM_RX,
        S_FUNC_RX,
        S_TX_DATA
    } state_t;

    localparam logic [15:0] RESET_MIN  = 16'(RESET_MIN_CYC);
    localparam logic [15:0] WAIT_END   = 16'(PRES_WAIT_CYC - 1);
    localparam logic [15:0] PRES_END   = 16'(PRES_LEN_CYC - 1);
    localparam logic [15:0] SAMPLE_END = 16'(SAMPLE_CYC - 1);
    localparam logic [15:0] HOLD_END   = 16'(TX_HOLD_CYC - 1);
    localparam logic [15:0] CONV_LD    = 16'(CONV_CYC);

    state_t      state_q, state_d;
    logic        dq_s1, dq_s, dq_d;
    logic        fall, rise, bus_reset;
    logic [15:0] low_cnt;
    logic [15:0] tmr;
    logic        slot_act;
    logic [2:0]  bit_cnt;
    logic [6:0]  sr;
    logic [3:0]  idx;
    logic        tx_bit;
    logic [15:0] scratch;
    logic [15:0] conv_cnt;
    logic        err_q;
    logic [7:0]  last_cmd_q;

    logic        drive, presence_c, err_set, conv_load;
    logic        rx_state, sample_now, byte_done, tx_end;
    logic [7:0]  rx_byte;

    // Bring DQ into the clock domain and keep one extra stage for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dq_s1 <= 1'b1;
            dq_s  <= 1'b1;
            dq_d  <= 1'b1;
        end else begin
            dq_s1 <= DQ;
            dq_s  <= dq_s1;
            dq_d  <= dq_s;
        end
    end

    assign fall      = dq_d & ~dq_s;
    assign rise      = ~dq_d & dq_s;
    assign bus_reset = rise && (low_cnt >= RESET_MIN);

    // Measure how long the master holds the line low; our own drive never counts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            low_cnt <= 16'd0;
        end else if (dq_s || drive) begin
            low_cnt <= 16'd0;
        end else if (low_cnt != 16'hFFFF) begin
            low_cnt <= low_cnt + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, line drive and one-cycle strobes; a bus reset overrides everything.
    always_comb begin
        state_d    = state_q;
        drive      = 1'b0;
        presence_c = 1'b0;
        err_set    = 1'b0;
        conv_load  = 1'b0;
        rx_state   = (state_q == S_ROM_RX) || (state_q == S_FUNC_RX);
        sample_now = rx_state && slot_act && (tmr == SAMPLE_END);
        byte_done  = sample_now && (bit_cnt == 3'd7);
        rx_byte    = {dq_s, sr};
        tx_end     = (state_q == S_TX_DATA) && slot_act && (tmr == HOLD_END);
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_PRES_WAIT: begin
                if (tmr == WAIT_END) state_d = S_PRES_DRIVE;
            end
            S_PRES_DRIVE: begin
                drive      = 1'b1;
                presence_c = (tmr == 16'd0);
                if (tmr == PRES_END) state_d = S_ROM_RX;
            end
            S_ROM_RX: begin
                if (byte_done) begin
                    if (rx_byte == 8'hCC) begin
                        state_d = S_FUNC_RX;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FUNC_RX: begin
                if (byte_done) begin
                    if (rx_byte == 8'h44) begin
                        conv_load = 1'b1;
                        state_d   = S_IDLE;
                    end else if (rx_byte == 8'hBE) begin
                        state_d = S_TX_DATA;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_TX_DATA: begin
                drive = slot_act && !tx_bit;
                if (tx_end && (idx == 4'd15)) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus_reset) begin
            state_d   = S_PRES_WAIT;
            err_set   = 1'b0;
            conv_load = 1'b0;
        end
    end

    // Slot timer, bit shifting and TX bit index; all of it restarts on every state change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmr      <= 16'd0;
            slot_act <= 1'b0;
            bit_cnt  <= 3'd0;
            sr       <= 7'd0;
            idx      <= 4'd0;
            tx_bit   <= 1'b1;
        end else if (bus_reset || (state_d != state_q)) begin
            tmr      <= 16'd0;
            slot_act <= 1'b0;
            bit_cnt  <= 3'd0;
            sr       <= 7'd0;
            idx      <= 4'd0;
        end else begin
            case (state_q)
                S_PRES_WAIT, S_PRES_DRIVE: begin
                    tmr <= tmr + 16'd1;
                end
                S_ROM_RX, S_FUNC_RX: begin
                    if (slot_act) begin
                        if (sample_now) begin
                            sr       <= rx_byte[7:1];
                            bit_cnt  <= bit_cnt + 3'd1;
                            slot_act <= 1'b0;
                            tmr      <= 16'd0;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end else if (fall) begin
                        slot_act <= 1'b1;
                        tmr      <= 16'd0;
                    end
                end
                S_TX_DATA: begin
                    if (slot_act) begin
                        if (tx_end) begin
                            slot_act <= 1'b0;
                            idx      <= idx + 4'd1;
                            tmr      <= 16'd0;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end else if (fall) begin
                        slot_act <= 1'b1;
                        tmr      <= 16'd0;
                        tx_bit   <= scratch[idx];
                    end
                end
                default: begin
                    tmr <= 16'd0;
                end
            endcase
        end
    end

    // Command capture and error strobe, updated on the cycle of the 8th sample.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q      <= 1'b0;
            last_cmd_q <= 8'h00;
        end else begin
            err_q <= err_set;
            if (byte_done && !bus_reset) last_cmd_q <= rx_byte;
        end
    end

    // Conversion timer and scratchpad; they run independently of the bus FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            conv_cnt <= 16'd0;
            scratch  <= 16'h0550;
        end else if (conv_load) begin
            conv_cnt <= CONV_LD;
            scratch  <= TEMP_IN;
        end else if (conv_cnt != 16'd0) begin
            conv_cnt <= conv_cnt - 16'd1;
        end
    end

    assign DQ       = drive ? 1'b0 : 1'bz;
    assign BUSY     = (conv_cnt != 16'd0);
    assign LAST_CMD = last_cmd_q;
    assign PRESENCE = presence_c;
    assign ERR      = err_q;

endmodule

// File: tb/tb_onewire_temp_responder.sv
// Bench for onewire_temp_responder.
// Timing parameters are scaled so that one clock cycle stands for one microsecond.
// A bus-level master drives DQ.
// The expected scratchpad comes from a simple model: power-on 0x0550, replaced by TEMP_IN at each Convert T.
module tb_onewire_temp_responder;

    localparam int RMIN  = 480;
    localparam int PWAIT = 30;
    localparam int PLEN  = 120;
    localparam int SAMP  = 30;
    localparam int THOLD = 30;
    localparam int CONV  = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_low = 1'b0;
    logic [15:0] temp_in = 16'h0191;
    wire         dq;
    logic        busy;
    logic [7:0]  last_cmd;
    logic        presence;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int pres_cnt = 0;
    int err_cnt = 0;
    int drv_cnt = 0;
    int busy_run = 0;
    int busy_last = 0;

    logic [15:0] model_scratch = 16'h0550;

    pullup (dq);
    assign dq = m_low ? 1'b0 : 1'bz;

    // Clock and reset generation.
    always #5 clk = ~clk;

    onewire_temp_responder #(
        .RESET_MIN_CYC(RMIN),
        .PRES_WAIT_CYC(PWAIT),
        .PRES_LEN_CYC (PLEN),
        .SAMPLE_CYC   (SAMP),
        .TX_HOLD_CYC  (THOLD),
        .CONV_CYC     (CONV)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .DQ      (dq),
        .TEMP_IN (temp_in),
        .BUSY    (busy),
        .LAST_CMD(last_cmd),
        .PRESENCE(presence),
        .ERR     (err)
    );

    // Event monitor, sampled 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (presence) pres_cnt++;
        if (err) err_cnt++;
        if (dq === 1'b0 && !m_low) drv_cnt++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            busy_last = busy_run;
            busy_run  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master driver tasks. Every task starts and ends on a falling clock edge.
    task automatic master_low(input int cycles);
        m_low = 1'b1;
        repeat (cycles) @(negedge clk);
        m_low = 1'b0;
    endtask

    task automatic watch(input int cycles, output int start, output int len);
        start = -1;
        len   = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (dq === 1'b0 && !m_low) begin
                if (start < 0) start = i;
                len++;
            end
        end
    endtask

    task automatic do_reset();
        int p, s, l;
        master_low(702);
        p = pres_cnt;
        watch(300, s, l);
        chk("presence_count", pres_cnt - p, 1);
        chk("presence_start_window", (s >= PWAIT - 3 && s <= PWAIT + 3), 1);
        chk("presence_len", l, PLEN);
    endtask

    task automatic write_bit(input logic b);
        int low;
        low = b ? int'($urandom_range(2, 8)) : int'($urandom_range(50, 60));
        master_low(low);
        repeat (70 - low) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) write_bit(b[i]);
    endtask

    task automatic read_bits(input int n, output logic [15:0] v);
        v = 16'h0000;
        for (int i = 0; i < n; i++) begin
            master_low(2);
            repeat (10) @(negedge clk);
            v[i] = (dq !== 1'b0);
            repeat (58) @(negedge clk);
        end
    endtask

    task automatic convert(input logic [15:0] t);
        temp_in = t;
        do_reset();
        write_byte(8'hCC);
        write_byte(8'h44);
        model_scratch = t;
    endtask

    task automatic read_scratch(input string tag);
        logic [15:0] v;
        do_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_bits(16, v);
        chk(tag, v, model_scratch);
    endtask

    task automatic wait_idle_busy();
        int n;
        n = 0;
        while (busy && n < CONV + 500) begin
            @(negedge clk);
            n++;
        end
        chk("busy_bounded", busy, 1'b0);
        @(negedge clk);
    endtask

    // Directed sequence with randomized data and slot timing.
    initial begin
        logic [15:0] v;
        logic [15:0] t;
        logic [7:0]  b;
        int d, e, p, s, l;

        repeat (3) @(negedge clk);
        chk("rst_dq", dq, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last_cmd", last_cmd, 8'h00);
        chk("rst_presence", presence, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Power-on scratchpad is served before any conversion.
        read_scratch("read_poweron");
        chk("last_cmd_be", last_cmd, 8'hBE);

        // Convert T with a fixed word: no drive during write slots, BUSY length.
        do_reset();
        temp_in = 16'h0191;
        d = drv_cnt;
        write_byte(8'hCC);
        write_byte(8'h44);
        model_scratch = 16'h0191;
        chk("write_no_drive", drv_cnt - d, 0);
        chk("last_cmd_44", last_cmd, 8'h44);
        chk("busy_after_convert", busy, 1'b1);
        temp_in = 16'($urandom);
        wait_idle_busy();
        chk("busy_len", busy_last, CONV);
        read_scratch("read_0191");

        // Randomized conversions, then a Convert T issued while BUSY.
        for (int k = 0; k < 2; k++) begin
            convert(16'($urandom));
            read_scratch("read_random");
        end
        convert(16'($urandom));
        t = 16'($urandom);
        convert(t);
        chk("busy_retrigger", busy, 1'b1);
        read_scratch("read_retrigger");
        wait_idle_busy();

        // Unsupported ROM byte 0x55, then a random one.
        do_reset();
        e = err_cnt;
        write_byte(8'h55);
        chk("rom55_err", err_cnt - e, 1);
        chk("rom55_last_cmd", last_cmd, 8'h55);
        d = drv_cnt;
        read_bits(8, v);
        chk("rom55_read_ones", v, 16'h00FF);
        chk("rom55_no_drive", drv_cnt - d, 0);
        b = 8'($urandom_range(0, 255));
        if (b == 8'hCC) b = 8'h33;
        do_reset();
        e = err_cnt;
        write_byte(b);
        chk("rom_rand_err", err_cnt - e, 1);
        chk("rom_rand_last_cmd", last_cmd, b);

        // Unsupported function byte after Skip ROM.
        b = 8'($urandom_range(0, 255));
        while (b == 8'h44 || b == 8'hBE) b = 8'($urandom_range(0, 255));
        do_reset();
        write_byte(8'hCC);
        e = err_cnt;
        write_byte(b);
        chk("func_rand_err", err_cnt - e, 1);
        chk("func_rand_last_cmd", last_cmd, b);

        // Bus reset after 5 TX bits aborts the read; a new read restarts at bit 0.
        convert(16'($urandom));
        do_reset();
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_bits(5, v);
        chk("abort_bits", v, {11'd0, model_scratch[4:0]});
        read_scratch("read_after_abort");

        // A 400-cycle low in IDLE is not a reset.
        master_low(400);
        p = pres_cnt;
        watch(300, s, l);
        chk("short_low_no_presence", pres_cnt - p, 0);
        chk("short_low_no_drive", l, 0);

        // RST_N asserted during the presence drive releases DQ immediately.
        convert(16'($urandom));
        master_low(702);
        watch(60, s, l);
        chk("mid_presence_dq", dq, 1'b0);
        chk("mid_presence_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dq", dq, 1'b1);
        chk("async_rst_presence", presence, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_last_cmd", last_cmd, 8'h00);
        chk("async_rst_err", err, 1'b0);
        model_scratch = 16'h0550;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        read_scratch("read_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
